// File: rtl/fft8_bfly_scheduler.sv
// 8-point DIT FFT butterfly scheduler: issues 3 stages x 4 butterfly reads,
// generates twiddle indices and PIPE_LAT-delayed write-back addresses.
//
// Ports:
//   i_clk, i_rst (sync, active-high), i_start (sampled in IDLE)
//   o_busy, o_done (1-cycle pulse after final write-back)
//   o_rd_en, o_rd_addr0/1, o_tw_idx, o_stage : read issue side
//   o_wr_en, o_wr_addr0/1                    : write-back side
module fft8_bfly_scheduler #(
  parameter int PIPE_LAT = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_rd_en,
  output logic [2:0] o_rd_addr0,
  output logic [2:0] o_rd_addr1,
  output logic [1:0] o_tw_idx,
  output logic [1:0] o_stage,
  output logic       o_wr_en,
  output logic [2:0] o_wr_addr0,
  output logic [2:0] o_wr_addr1
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [2:0] a0;
    logic [2:0] a1;
    logic [1:0] tw;
  } rd_t;

  typedef struct packed {
    logic       vld;
    logic [2:0] a0;
    logic [2:0] a1;
  } wb_t;

  localparam logic [3:0] DRAIN_LEN = 4'(PIPE_LAT);

  state_t     state;
  logic [1:0] stage;
  logic [1:0] k;
  logic [3:0] cnt;
  logic       busy_q;
  logic       done_q;
  logic       rd_en_q;
  rd_t        rd_q;
  logic [1:0] rd_stage_q;
  wb_t        pipe [PIPE_LAT];
  logic       pending;

  // Operand pair for butterfly k of a stage: the stage bit is inserted
  // into k as a zero (addr0) or one (addr1).
  function automatic rd_t addr_gen(
    input logic [1:0] stg,
    input logic [1:0] kk
  );
    logic [2:0] span;
    logic [2:0] pos;
    logic [2:0] grp;
    logic [2:0] shf;
    rd_t        r;
    span = 3'd1 << stg;
    pos  = {1'b0, kk} & (span - 3'd1);
    grp  = {1'b0, kk} >> stg;
    r.a0 = ((grp << 1) << stg) | pos;
    r.a1 = r.a0 + span;
    shf  = pos << (2'd2 - stg);
    r.tw = shf[1:0];
    return r;
  endfunction

  // Reads still in flight that have not yet reached the tail.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < PIPE_LAT - 1; i++) begin
      pending = pending | pipe[i].vld;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      stage      <= 2'd0;
      k          <= 2'd0;
      cnt        <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_q       <= '0;
      rd_stage_q <= 2'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            state      <= ISSUE;
            stage      <= 2'd0;
            k          <= 2'd0;
            busy_q     <= 1'b1;
            rd_en_q    <= 1'b1;
            rd_q       <= addr_gen(2'd0, 2'd0);
            rd_stage_q <= 2'd0;
          end
        end
        ISSUE: begin
          if (k == 2'd3) begin
            state      <= DRAIN;
            k          <= 2'd0;
            cnt        <= DRAIN_LEN;
            rd_en_q    <= 1'b0;
            rd_q       <= '0;
            rd_stage_q <= 2'd0;
          end else begin
            k    <= k + 2'd1;
            rd_q <= addr_gen(stage, k + 2'd1);
          end
        end
        DRAIN: begin
          if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
          end else if (stage != 2'd2) begin
            state      <= ISSUE;
            stage      <= stage + 2'd1;
            k          <= 2'd0;
            rd_en_q    <= 1'b1;
            rd_q       <= addr_gen(stage + 2'd1, 2'd0);
            rd_stage_q <= stage + 2'd1;
          end else begin
            // Final stage: leave only once the last write is at the tail.
            cnt <= 4'd0;
            if (!pending) begin
              state  <= IDLE;
              stage  <= 2'd0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write-back delay line; a read shown in cycle c appears at the tail
  // in cycle c+PIPE_LAT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= wb_t'({rd_en_q, rd_q.a0, rd_q.a1});
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_rd_en    = rd_en_q;
  assign o_rd_addr0 = rd_q.a0;
  assign o_rd_addr1 = rd_q.a1;
  assign o_tw_idx   = rd_q.tw;
  assign o_stage    = rd_stage_q;
  assign o_wr_en    = pipe[PIPE_LAT-1].vld;
  assign o_wr_addr0 = pipe[PIPE_LAT-1].a0;
  assign o_wr_addr1 = pipe[PIPE_LAT-1].a1;

endmodule

// File: tb/tb_fft8_bfly_scheduler.sv
// Bench for fft8_bfly_scheduler: three instances (PIPE_LAT 1, 2, 5) driven
// by shared stimulus and checked each cycle against a timing-table model.
module tb_fft8_bfly_scheduler;

  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic       busy [3];
  logic       done [3];
  logic       rd_en [3];
  logic       wr_en [3];
  logic [2:0] rd0 [3];
  logic [2:0] rd1 [3];
  logic [2:0] wr0 [3];
  logic [2:0] wr1 [3];
  logic [1:0] tw [3];
  logic [1:0] stg [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fft8_bfly_scheduler #(
      .PIPE_LAT(g == 0 ? 1 : (g == 1 ? 2 : 5))
    ) u_dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start),
      .o_busy    (busy[g]),
      .o_done    (done[g]),
      .o_rd_en   (rd_en[g]),
      .o_rd_addr0(rd0[g]),
      .o_rd_addr1(rd1[g]),
      .o_tw_idx  (tw[g]),
      .o_stage   (stg[g]),
      .o_wr_en   (wr_en[g]),
      .o_wr_addr0(wr0[g]),
      .o_wr_addr1(wr1[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;

  // Butterfly pairings and twiddles per stage, as tabulated.
  int p0 [3][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
  int p1 [3][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
  int pt [3][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

  // t = cycle number within the current transform (0 = idle).
  int t [3] = '{0, 0, 0};

  function automatic int lat_of(int i);
    return i == 0 ? 1 : (i == 1 ? 2 : 5);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) t[i] = 0;
      else if (t[i] == 0 || t[i] == 13 + 3 * lat_of(i)) t[i] = start ? 1 : 0;
      else t[i] = t[i] + 1;
    end
  end

  task automatic issue_at(input int L, input int tt,
                          output bit v, output int s, output int kk);
    int off;
    v = 0; s = 0; kk = 0;
    if (tt >= 1 && tt <= 12 + 3 * L) begin
      off = (tt - 1) % (4 + L);
      if (off < 4) begin
        v = 1;
        s = (tt - 1) / (4 + L);
        kk = off;
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (time %0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      int L, d, s, kk, ws, wk;
      bit v, wv;
      L = lat_of(i);
      d = 13 + 3 * L;
      issue_at(L, t[i], v, s, kk);
      issue_at(L, t[i] - L, wv, ws, wk);
      chk($sformatf("L%0d busy", L), int'(busy[i]), int'(t[i] >= 1 && t[i] < d));
      chk($sformatf("L%0d done", L), int'(done[i]), int'(t[i] == d));
      chk($sformatf("L%0d rd_en", L), int'(rd_en[i]), int'(v));
      chk($sformatf("L%0d rd_addr0", L), int'(rd0[i]), v ? p0[s][kk] : 0);
      chk($sformatf("L%0d rd_addr1", L), int'(rd1[i]), v ? p1[s][kk] : 0);
      chk($sformatf("L%0d tw_idx", L), int'(tw[i]), v ? pt[s][kk] : 0);
      chk($sformatf("L%0d stage", L), int'(stg[i]), v ? s : 0);
      chk($sformatf("L%0d wr_en", L), int'(wr_en[i]), int'(wv));
      chk($sformatf("L%0d wr_addr0", L), int'(wr0[i]), wv ? p0[ws][wk] : 0);
      chk($sformatf("L%0d wr_addr1", L), int'(wr1[i]), wv ? p1[ws][wk] : 0);
    end
  endtask

  // Golden data memory plus butterfly, driven by the PIPE_LAT=2 instance.
  bit  fft_on = 0;
  real mre [8];
  real mim [8];
  real q0r [$];
  real q0i [$];
  real q1r [$];
  real q1i [$];

  always @(posedge clk) begin
    if (fft_on) begin
      if (wr_en[1] && q0r.size() > 0) begin
        mre[wr0[1]] = q0r.pop_front();
        mim[wr0[1]] = q0i.pop_front();
        mre[wr1[1]] = q1r.pop_front();
        mim[wr1[1]] = q1i.pop_front();
      end
      if (rd_en[1]) begin
        real wre, wim, br, bi, pr, pi_;
        wre = $cos(PI * real'(tw[1]) / 4.0);
        wim = -$sin(PI * real'(tw[1]) / 4.0);
        br  = mre[rd1[1]];
        bi  = mim[rd1[1]];
        pr  = wre * br - wim * bi;
        pi_ = wre * bi + wim * br;
        q0r.push_back(mre[rd0[1]] + pr);
        q0i.push_back(mim[rd0[1]] + pi_);
        q1r.push_back(mre[rd0[1]] - pr);
        q1i.push_back(mim[rd0[1]] - pi_);
      end
    end
  end

  task automatic chk_bin(input string nm, input real ar, input real ai,
                         input real er, input real ei);
    real dr, di;
    dr = ar - er;
    di = ai - ei;
    if (dr < 0.0) dr = -dr;
    if (di < 0.0) di = -di;
    n_cmp++;
    if (dr > 1e-3 || di > 1e-3) begin
      n_err++;
      $display("FAIL %s: got (%f,%f), want (%f,%f)", nm, ar, ai, er, ei);
    end
  endtask

  task automatic run_fft(input bit ones);
    bit seen;
    for (int n = 0; n < 8; n++) begin
      mre[n] = (ones || n == 0) ? 1.0 : 0.0;
      mim[n] = 0.0;
    end
    fft_on = 1;
    start = 1;
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      compare_all();
      start = 0;
      seen = done[1];
    end
    chk(ones ? "fft ones done" : "fft impulse done", int'(seen), 1);
    fft_on = 0;
    for (int n = 0; n < 8; n++) begin
      if (ones)
        chk_bin($sformatf("ones X[%0d]", n), mre[n], mim[n], n == 0 ? 8.0 : 0.0, 0.0);
      else
        chk_bin($sformatf("impulse X[%0d]", n), mre[n], mim[n], 1.0, 0.0);
    end
  endtask

  initial begin
    int dc;
    repeat (2) @(negedge clk);
    compare_all();
    chk("reset busy", int'(busy[1]), 0);
    rst = 0;

    // Directed run with a stray start at cycle 6.
    start = 1;
    dc = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      compare_all();
      dc += int'(done[1]);
      if (c == 5) chk("c5 rd_en", int'(rd_en[1]), 0);
      if (c == 8) begin
        chk("c8 rd_en", int'(rd_en[1]), 1);
        chk("c8 tw", int'(tw[1]), 2);
        chk("c8 stage", int'(stg[1]), 1);
      end
      if (c == 13) begin
        chk("c13 rd0", int'(rd0[1]), 0);
        chk("c13 rd1", int'(rd1[1]), 4);
        chk("c13 stage", int'(stg[1]), 2);
      end
      if (c == 16) begin
        chk("c16 rd0", int'(rd0[1]), 3);
        chk("c16 rd1", int'(rd1[1]), 7);
        chk("c16 tw", int'(tw[1]), 3);
        chk("L1 done c16", int'(done[0]), 1);
      end
      if (c == 18) begin
        chk("c18 busy", int'(busy[1]), 1);
        chk("c18 wr_en", int'(wr_en[1]), 1);
        chk("c18 wr0", int'(wr0[1]), 3);
        chk("c18 wr1", int'(wr1[1]), 7);
      end
      if (c == 19) begin
        chk("c19 done", int'(done[1]), 1);
        chk("c19 busy", int'(busy[1]), 0);
      end
      if (c == 28) chk("L5 done c28", int'(done[2]), 1);
      start = (c == 6);
    end
    chk("single done", dc, 1);

    // Reset at stage 1, k=2.
    start = 1;
    dc = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      compare_all();
      dc += int'(done[1]);
      if (c == 10) begin
        chk("post-rst busy", int'(busy[1]), 0);
        chk("post-rst rd_en", int'(rd_en[1]), 0);
        chk("post-rst wr_en", int'(wr_en[1]), 0);
      end
      start = 0;
      rst = (c == 9);
    end
    chk("abort no done", dc, 0);

    // Clean restart.
    start = 1;
    dc = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      compare_all();
      dc += int'(done[1]);
      if (c == 1) begin
        chk("restart rd0", int'(rd0[1]), 0);
        chk("restart rd1", int'(rd1[1]), 1);
        chk("restart stage", int'(stg[1]), 0);
      end
      start = 0;
    end
    chk("restart done", dc, 1);

    // Start held high: back-to-back transforms.
    start = 1;
    dc = 0;
    for (int c = 1; c <= 95; c++) begin
      @(negedge clk);
      compare_all();
      dc += int'(done[1]);
    end
    chk("b2b done count", dc, 5);
    start = 0;
    repeat (30) begin
      @(negedge clk);
      compare_all();
    end

    // Randomized start/reset traffic.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      compare_all();
      start = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 299) == 0);
    end

    // Numeric FFT through the golden memory and butterfly.
    start = 0;
    rst = 1;
    @(negedge clk);
    compare_all();
    rst = 0;
    run_fft(1'b0);
    repeat (3) @(negedge clk);
    run_fft(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
